// File: rtl/reg_dec_pkg.sv
// Shared constants and types for the reg_dec decrementing counter.
package reg_dec_pkg;

  localparam int unsigned REG_DEC_WIDTH_DEF = 8;
  localparam logic [7:0]  REG_DEC_INIT_DEF  = 8'hFF;
  localparam int unsigned REG_DEC_STEP_DEF  = 1;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

endpackage

// File: rtl/reg_dec_next.sv
// Combinational next-value and underflow calculator for reg_dec.
module reg_dec_next
  import reg_dec_pkg::*;
#(
  parameter int unsigned WIDTH    = REG_DEC_WIDTH_DEF,
  parameter int unsigned STEP     = REG_DEC_STEP_DEF,
  parameter bit          SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             enable,
  output logic [WIDTH-1:0] nxt,
  output logic             underflow
);

  localparam int unsigned EXT_W = WIDTH + 1;
  localparam mode_e       MODE  = SATURATE ? MODE_SAT : MODE_WRAP;

  logic [WIDTH:0] diff;
  logic           borrow;

  // Extra MSB of the widened subtraction is the borrow out
  assign diff   = {1'b0, cur} - EXT_W'(STEP);
  assign borrow = diff[WIDTH];

  always_comb begin
    nxt       = cur;
    underflow = 1'b0;
    if (enable) begin
      if (borrow && (MODE == MODE_SAT)) begin
        nxt = '0;
      end else begin
        nxt = diff[WIDTH-1:0];
      end
      underflow = borrow || (diff[WIDTH-1:0] == '0);
    end
  end

endmodule

// File: rtl/reg_dec.sv
// Parameterised down-counter register with wrap or saturate underflow.
// Optional terminal-count pulse o_tc when REG_DEC_TERMINAL_EN is defined.
module reg_dec
  import reg_dec_pkg::*;
#(
  parameter int unsigned      WIDTH      = REG_DEC_WIDTH_DEF,
  parameter logic [WIDTH-1:0] INIT_VALUE = '1,
  parameter int unsigned      STEP       = REG_DEC_STEP_DEF,
  parameter bit               SATURATE   = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             enable,
  output logic [WIDTH-1:0] o_data
`ifdef REG_DEC_TERMINAL_EN
  ,
  output logic             o_tc
`endif
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_nxt;
  logic             uf;

  reg_dec_next #(
    .WIDTH   (WIDTH),
    .STEP    (STEP),
    .SATURATE(SATURATE)
  ) u_next (
    .cur      (cnt_q),
    .enable   (enable),
    .nxt      (cnt_nxt),
    .underflow(uf)
  );

  // i_rst_n is active-high despite its name
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      cnt_q <= INIT_VALUE;
    end else begin
      cnt_q <= cnt_nxt;
    end
  end

  assign o_data = cnt_q;

`ifdef REG_DEC_TERMINAL_EN
  logic tc_q;

  // uf is already low on hold cycles, so no separate enable gating is needed
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= uf;
    end
  end

  assign o_tc = tc_q;
`else
  logic unused_uf;
  assign unused_uf = uf;
`endif

endmodule

// File: tb/tb_reg_dec.sv
// Self-checking bench for reg_dec: a wrap-mode and a saturate-mode instance driven together.
module tb_reg_dec;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] dw;
  logic [7:0] ds;
`ifdef REG_DEC_TERMINAL_EN
  logic       tcw;
  logic       tcs;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state
  int mw;
  int ms;

  typedef struct packed {
    logic [7:0] w;
    logic [7:0] s;
    logic       tw;
    logic       ts;
  } exp_t;

  exp_t q[$];

  typedef struct {
    logic       rst;
    logic       en;
    int         n;
    logic [7:0] exp_w;
    logic [7:0] exp_s;
  } vec_t;

  vec_t vecs[14];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_dec dut_w (
    .i_clk  (clk),
    .i_rst_n(rst),
    .enable (en),
    .o_data (dw)
`ifdef REG_DEC_TERMINAL_EN
    ,
    .o_tc   (tcw)
`endif
  );

  reg_dec #(
    .WIDTH     (8),
    .INIT_VALUE(8'h07),
    .STEP      (3),
    .SATURATE  (1'b1)
  ) dut_s (
    .i_clk  (clk),
    .i_rst_n(rst),
    .enable (en),
    .o_data (ds)
`ifdef REG_DEC_TERMINAL_EN
    ,
    .o_tc   (tcs)
`endif
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, push expectation, compare 1ns after the rising edge
  task automatic cyc(input logic r, input logic e);
    exp_t x;
    @(negedge clk);
    rst = r;
    en  = e;
    x.tw = 1'b0;
    x.ts = 1'b0;
    if (r) begin
      mw = 255;
      ms = 7;
    end else if (e) begin
      x.tw = (mw == 0) || (mw == 1);
      x.ts = (ms <= 3);
      mw   = (mw + 255) % 256;
      ms   = (ms >= 3) ? ms - 3 : 0;
    end
    x.w = 8'(mw);
    x.s = 8'(ms);
    q.push_back(x);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      x = q.pop_front();
      chk("wrap_data", dw, x.w);
      chk("sat_data", ds, x.s);
`ifdef REG_DEC_TERMINAL_EN
      chk("wrap_tc", 8'(tcw), 8'(x.tw));
      chk("sat_tc", 8'(tcs), 8'(x.ts));
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    mw  = 255;
    ms  = 7;

    // {rst, en, cycles, wrap value after, saturate value after}
    vecs[0]  = '{1'b1, 1'b1, 2,   8'hFF, 8'h07};
    vecs[1]  = '{1'b0, 1'b1, 1,   8'hFE, 8'h04};
    vecs[2]  = '{1'b0, 1'b1, 1,   8'hFD, 8'h01};
    vecs[3]  = '{1'b0, 1'b1, 1,   8'hFC, 8'h00};
    vecs[4]  = '{1'b0, 1'b1, 12,  8'hF0, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 5,   8'hF0, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, 1,   8'hEF, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 111, 8'h80, 8'h00};
    vecs[8]  = '{1'b1, 1'b1, 1,   8'hFF, 8'h07};
    vecs[9]  = '{1'b0, 1'b1, 1,   8'hFE, 8'h04};
    vecs[10] = '{1'b1, 1'b1, 3,   8'hFF, 8'h07};
    vecs[11] = '{1'b0, 1'b1, 255, 8'h00, 8'h00};
    vecs[12] = '{1'b0, 1'b1, 1,   8'hFF, 8'h00};
    vecs[13] = '{1'b0, 1'b1, 1,   8'hFE, 8'h00};

    for (int i = 0; i < 14; i++) begin
      repeat (vecs[i].n) cyc(vecs[i].rst, vecs[i].en);
      chk($sformatf("vec%0d_wrap", i), dw, vecs[i].exp_w);
      chk($sformatf("vec%0d_sat", i), ds, vecs[i].exp_s);
    end

    // Hand sequence: reset, saturate to zero, hold there, then confirm a plain hold keeps value
    cyc(1'b1, 1'b0);
    chk("seq_reset_wrap", dw, 8'hFF);
    chk("seq_reset_sat", ds, 8'h07);
    repeat (4) cyc(1'b0, 1'b1);
    chk("seq_sat_floor", ds, 8'h00);
    chk("seq_wrap_fb", dw, 8'hFB);
    repeat (3) cyc(1'b0, 1'b0);
    chk("seq_hold_wrap", dw, 8'hFB);
`ifdef REG_DEC_TERMINAL_EN
    chk("seq_hold_tc", 8'(tcs), 8'h00);
`endif

    // Hand sequence: approach zero and wrap through it
    cyc(1'b1, 1'b1);
    repeat (254) cyc(1'b0, 1'b1);
    chk("seq_at_one", dw, 8'h01);
    cyc(1'b0, 1'b1);
    chk("seq_at_zero", dw, 8'h00);
`ifdef REG_DEC_TERMINAL_EN
    chk("seq_tc_zero", 8'(tcw), 8'h01);
`endif
    cyc(1'b0, 1'b1);
    chk("seq_wrapped", dw, 8'hFF);
`ifdef REG_DEC_TERMINAL_EN
    chk("seq_tc_wrap", 8'(tcw), 8'h01);
`endif
    cyc(1'b0, 1'b1);
    chk("seq_after_wrap", dw, 8'hFE);
`ifdef REG_DEC_TERMINAL_EN
    chk("seq_tc_clear", 8'(tcw), 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
